// File: rtl/cond_pkg.sv
// cond_pkg: condition-code encodings and NZCV flag bit positions
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates a 4-bit condition field against NZCV flags
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition table; the unencoded value 4'hF falls into default and executes
    always_comb begin
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/flags_cond_stage.sv
// flags_cond_stage: NZCV flags register, condition gating and EX/MEM handoff register
module flags_cond_stage
    import cond_pkg::*;
#(
    parameter int N    = 32,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    alu_result,
    input  logic [3:0]      alu_flags,
    input  logic [3:0]      cond,
    input  logic [1:0]      flag_w,
    input  logic            reg_w,
    input  logic            mem_w,
    input  logic            pc_s,
    input  logic [RA_W-1:0] wa3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RA_W-1:0] out_wa3,
    output logic            out_reg_w,
    output logic            out_mem_w,
    output logic            out_pc_s,
    output logic [3:0]      flags_q
);

    logic            cond_ex, accept;
    logic [3:0]      flags_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_result_q, out_result_d;
    logic [RA_W-1:0] out_wa3_q, out_wa3_d;
    logic [2:0]      out_en_q, out_en_d;

    // Condition is judged against the flags before this instruction's own update
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Flags change only for an accepted, executed instruction, per flag pair
    always_comb begin
        flags_d = flags_q;
        if (accept && cond_ex && flag_w[1]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (accept && cond_ex && flag_w[0]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    // EX/MEM slot: flush kills, accept loads, a drain with no refill empties
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_wa3_d    = out_wa3_q;
        out_en_d     = out_en_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_wa3_d    = wa3;
            out_en_d     = {reg_w, mem_w, pc_s} & {3{cond_ex}};
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_wa3_q    <= '0;
            out_en_q     <= '0;
        end else begin
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_wa3_q    <= out_wa3_d;
            out_en_q     <= out_en_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_wa3    = out_wa3_q;
    assign out_reg_w  = out_en_q[2];
    assign out_mem_w  = out_en_q[1];
    assign out_pc_s   = out_en_q[0];

endmodule
